// File: rtl/mic_mem_pkg.sv
// mic_mem_pkg -- shared definitions for the MIC memory port.
//   state_t      : port FSM state (IDLE, WAIT)
//   DEF_ADDR_W   : default MAR / memory address width
//   DEF_DATA_W   : default MDR / memory data width
//   DEF_SHIFT    : default word-to-byte address shift
//   DEF_TIMEOUT  : default wait-state limit for the optional watchdog
package mic_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SHIFT   = 2;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/mic_mem_watchdog.sv
// mic_mem_watchdog -- wait-state counter for the memory port.
// Counts cycles while run is high and raises expire during the LIMIT-th
// cycle, so the owner leaves WAIT on that edge. The count clears whenever
// run is low, so every new transaction starts from zero.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   run        : owner is waiting on memory
//   expire     : LIMIT cycles have elapsed in the current wait
module mic_mem_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expire
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] cnt_reg;

  // cnt_reg holds the number of completed wait cycles minus one edge,
  // so hitting LIMIT-1 means this is the LIMIT-th cycle of the wait.
  assign expire = run && (cnt_reg == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (!run) begin
      cnt_reg <= '0;
    end else if (!expire) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mic_mem_port.sv
// mic_mem_port -- combined MAR/MDR unit with a main-memory request port.
// Loads MAR/MDR from the C bus, converts the word address in MAR to a byte
// address, runs one read or write at a time against memory with any number
// of wait states, and holds busy high so the microsequencer stalls.
// Optional feature macro: MIC_MEM_TIMEOUT_EN (adds the wait-state watchdog
// and the sticky err flag; without it err is constant 0).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   enaMar, enaMdr      : load MAR / MDR from inputC
//   inputC              : C-bus value
//   rd, wr              : start a read / write (both -> write)
//   marOut, mdrOut      : current MAR, current MDR (B bus)
//   busy                : transaction outstanding
//   mem_req, mem_we     : memory request and direction
//   mem_addr, mem_wdata : latched byte address and write data
//   mem_ack, mem_rdata  : memory completion and read data
//   err                 : sticky timeout flag
module mic_mem_port
  import mic_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WORD_SHIFT = DEF_SHIFT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enaMar,
  input  logic              enaMdr,
  input  logic [DATA_W-1:0] inputC,
  input  logic              rd,
  input  logic              wr,
  output logic [ADDR_W-1:0] marOut,
  output logic [DATA_W-1:0] mdrOut,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  state_t            state_reg;
  logic [ADDR_W-1:0] mar_reg;
  logic [DATA_W-1:0] mdr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              we_reg;
  logic              err_reg;

  logic [ADDR_W-1:0] c_addr;
  logic [ADDR_W-1:0] start_addr;
  logic              start;
  logic              wd_expire;

  // C bus to address width: plain truncation or zero extension, never sign
  // extension, since MAR is an unsigned word address.
  generate
    if (ADDR_W <= DATA_W) begin : g_addr_trunc
      assign c_addr = inputC[ADDR_W-1:0];
    end else begin : g_addr_zext
      assign c_addr = {{(ADDR_W - DATA_W){1'b0}}, inputC};
    end
  endgenerate

  // A same-cycle MAR load is forwarded straight into the request.
  assign start_addr = enaMar ? c_addr : mar_reg;
  assign start      = rd | wr;

`ifdef MIC_MEM_TIMEOUT_EN
  mic_mem_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .run    (state_reg == WAIT),
    .expire (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
  // TIMEOUT only matters when the watchdog is built in.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      mar_reg   <= '0;
      mdr_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      // MAR is free to change at any time; the in-flight address is latched.
      if (enaMar) begin
        mar_reg <= c_addr;
      end
      case (state_reg)
        IDLE: begin
          if (enaMdr) begin
            mdr_reg <= inputC;
          end
          if (start) begin
            state_reg <= WAIT;
            addr_reg  <= start_addr << WORD_SHIFT;
            we_reg    <= wr;
            if (wr) begin
              wdata_reg <= enaMdr ? inputC : mdr_reg;
            end
          end
        end
        WAIT: begin
          // During a read MDR is reserved for the returning data.
          if (enaMdr && we_reg) begin
            mdr_reg <= inputC;
          end
          if (mem_ack) begin
            if (!we_reg) begin
              mdr_reg <= mem_rdata;
            end
            state_reg <= IDLE;
          end else if (wd_expire) begin
            state_reg <= IDLE;
            err_reg   <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign marOut    = mar_reg;
  assign mdrOut    = mdr_reg;
  assign busy      = (state_reg == WAIT);
  assign mem_req   = (state_reg == WAIT);
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign err       = err_reg;

endmodule

// File: doc/mic_mem_port.md
# mic_mem_port

Parametrised memory port for the MIC datapath, generalising the original memory address register into a combined MAR/MDR unit with its own request handshake. It loads address and data from the C bus, converts word addresses to byte addresses, runs read/write transactions against main memory with arbitrary wait states, and stalls the microsequencer while a transaction is outstanding. It sits between the C/B buses and the main-memory interface.

## Interface
- ADDR_W, 32, width of MAR and memory address
- DATA_W, 32, width of MDR and memory data
- WORD_SHIFT, 2, left shift from word address (MAR) to byte address (0 = byte-addressed memory)
- TIMEOUT, 255, wait-state limit used only with MIC_MEM_TIMEOUT_EN
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- enaMar  in  1  load MAR from inputC
- enaMdr  in  1  load MDR from inputC
- inputC  in  DATA_W  signed C-bus value
- rd  in  1  start a read of MAR
- wr  in  1  start a write of MDR to MAR
- marOut  out  ADDR_W  current MAR (unsigned)
- mdrOut  out  DATA_W  current MDR, drives B bus
- busy  out  1  transaction outstanding; microsequencer must stall
- mem_req  out  1  request valid to memory
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  byte address = latched word address << WORD_SHIFT, truncated to ADDR_W
- mem_wdata  out  DATA_W  latched write data
- mem_ack  in  1  memory completes current request (sampled on posedge)
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- err  out  1  sticky timeout flag

## Operation
- Reset: MAR, MDR, mem_addr, mem_wdata = 0; mem_req, mem_we, busy, err = 0; state IDLE.
- inputC is truncated/zero-extended to ADDR_W on MAR load; no sign extension.
- FSM states: IDLE, WAIT.
- IDLE: rd or wr starts a transaction -> WAIT; latch address and we; wr latches write data.
- rd and wr together: treated as write; read dropped.
- Same-cycle forwarding: enaMar with rd/wr uses inputC as address; enaMdr with wr uses inputC as write data.
- WAIT: mem_req held high with stable mem_addr/mem_we/mem_wdata until mem_ack.
- On mem_ack: read loads MDR from mem_rdata; -> IDLE.
- rd/wr while in WAIT: ignored.
- enaMar while busy: MAR updates; in-flight address unaffected.
- enaMdr during an outstanding read: ignored. During an outstanding write: MDR updates; mem_wdata unaffected.
- mem_ack in IDLE: ignored.

## Timing
- rd/wr sampled at edge N -> mem_req, busy high after edge N.
- mem_ack sampled at edge N+k (k ≥ 1) -> MDR valid, busy and mem_req low after that edge. Minimum transaction is 1 cycle of mem_req.
- Back-to-back transactions: a new rd/wr is accepted in the first IDLE cycle after completion.
- Reset asserted mid-transaction: immediate return to IDLE, mem_req low, no MDR update.

## Configuration
- MIC_MEM_TIMEOUT_EN defined: a counter runs in WAIT. After TIMEOUT cycles without mem_ack, mem_req drops, the FSM returns to IDLE, MDR is unchanged, and err sets (sticky until reset). The counter clears on every entry to WAIT.
- Not defined: err tied to 0; WAIT lasts indefinitely until mem_ack.

## Structure
- Package mic_mem_pkg: FSM state enum (IDLE, WAIT) and default width/shift constants.
- One sub-module, mic_mem_watchdog (counter + expiry pulse), instantiated only under MIC_MEM_TIMEOUT_EN.

## Test plan
- enaMar with inputC=0x00000010 then rd, memory acks after 3 wait cycles with 0xCAFEF00D -> mem_addr=0x40 with mem_we=0 for 3 cycles; then mdrOut=0xCAFEF00D and busy low.
- Same cycle enaMar (inputC=0x5), enaMdr not used, wr with MDR=0x1234 -> mem_addr=0x14, mem_we=1, mem_wdata=0x1234.
- rd and wr together -> write performed; MDR unchanged after ack.
- rd re-pulsed and enaMar=0x99 during WAIT -> no second request; mem_addr stays at the original value; marOut=0x99.
- Reset raised two cycles into WAIT -> mem_req/busy low asynchronously; all outputs 0.
- With MIC_MEM_TIMEOUT_EN and TIMEOUT=4, no ack -> mem_req drops after 4 cycles, err=1 and stays 1 across later transactions until reset.
